event_debounce: RTL and testbench

Input conditioner that sits directly upstream of the counter block. It takes an asynchronous raw event input, synchronises it, debounces it, and emits single-cycle pulses. o_event drives the counter's i_en and o_clear drives its i_clear. A long press (input held active) produces a one-shot clear request.

---
 rtl/event_debounce.sv | 163 ++++++++++++++++
 tb/tb_event_debounce.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_debounce.sv
// Raw event conditioner: synchronises an asynchronous input, debounces it and
// turns accepted transitions and long presses into single-cycle pulses.
module event_debounce #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int EDGE_MODE         = 0,
    parameter int LONG_PRESS_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_raw,
    output logic o_level,
    output logic o_event,
    output logic o_clear,
    output logic o_busy
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCNT_W = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("event_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("event_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge
        $error("event_debounce: EDGE_MODE must be 0, 1 or 2");
    end
    if (LONG_PRESS_CYCLES < 0) begin : g_bad_long
        $error("event_debounce: LONG_PRESS_CYCLES must be >= 0");
    end

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic                   accept;
    logic                   level_d;
    logic                   fire;
    logic                   event_q;

    // Only the first flop of this chain ever looks at i_raw.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: defaults first so every path assigns every output; without
        // them the missing branches would infer latches.
        state_d = state_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != o_level) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                        dcnt_d  = DCNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (s == o_level) begin
                    state_d = ST_STABLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // This sample is the DEBOUNCE_CYCLES-th consecutive one.
                    accept  = 1'b1;
                    state_d = ST_STABLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                dcnt_d  = '0;
            end
        endcase
    end

    assign level_d = o_level ^ accept;

    always_comb begin
        fire = 1'b0;
        case (EDGE_MODE)
            0:       fire = accept && !o_level;
            1:       fire = accept &&  o_level;
            default: fire = accept;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_STABLE;
            dcnt_q  <= '0;
            o_level <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            o_level <= level_d;
            // With one-sample debounce the level can flip every cycle; the
            // back-to-back guard keeps o_event a strict single-cycle pulse.
            event_q <= fire && i_enable && !event_q;
        end
    end

    assign o_event = event_q;
    assign o_busy  = (state_q == ST_CHECK);

    if (LONG_PRESS_CYCLES > 0) begin : g_long
        logic [HCNT_W-1:0] hcnt_q;
        logic              fired_q;
        logic              clear_q;

        // Counting only while the level is high now and stays high this edge
        // keeps a clear from ever landing on the same cycle as a falling event.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hcnt_q  <= '0;
                fired_q <= 1'b0;
                clear_q <= 1'b0;
            end else begin
                clear_q <= 1'b0;
                if (!o_level || !level_d) begin
                    hcnt_q  <= '0;
                    fired_q <= 1'b0;
                end else if (!i_enable) begin
                    hcnt_q <= '0;
                end else if (hcnt_q != HCNT_W'(LONG_PRESS_CYCLES)) begin
                    hcnt_q <= hcnt_q + 1'b1;
                    if (hcnt_q == HCNT_W'(LONG_PRESS_CYCLES - 1) && !fired_q) begin
                        clear_q <= 1'b1;
                        fired_q <= 1'b1;
                    end
                end
            end
        end

        assign o_clear = clear_q;
    end else begin : g_no_long
        assign o_clear = 1'b0;
    end

endmodule

// File: tb/tb_event_debounce.sv
// Directed bench for event_debounce: three instances (rising, falling, both
// edges) share one stimulus; a small counter model stands in for the consumer.
module tb_event_debounce;

    logic clk;
    logic rst_n;
    logic enable;
    logic raw;

    logic r_level, r_event, r_clear, r_busy;
    logic f_level, f_event, f_clear, f_busy;
    logic b_level, b_event, b_clear, b_busy;

    event_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .LONG_PRESS_CYCLES(20)) dut_rise (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_raw(raw),
        .o_level(r_level), .o_event(r_event), .o_clear(r_clear), .o_busy(r_busy)
    );
    event_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .LONG_PRESS_CYCLES(20)) dut_fall (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_raw(raw),
        .o_level(f_level), .o_event(f_event), .o_clear(f_clear), .o_busy(f_busy)
    );
    event_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .LONG_PRESS_CYCLES(20)) dut_both (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_raw(raw),
        .o_level(b_level), .o_event(b_event), .o_clear(b_clear), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer counter model: clear wins over enable.
    logic [11:0] cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (r_clear) cnt <= '0;
        else if (r_event) cnt <= cnt + 12'd1;
    end

    // Negedge monitor: pulse counts and the edge index at which things happened.
    int ev_r = 0, ev_f = 0, ev_b = 0, clr_n = 0, busy_rises = 0, level_rises = 0;
    int ev_r_cyc = 0, ev_f_cyc = 0, clr_cyc = 0, rise_cyc = 0, cnt_zero_cyc = 0;
    int consec = 0;
    logic pe_r = 0, pe_f = 0, pe_b = 0, pc = 0, pl = 0, pb = 0;
    logic [11:0] pcnt = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (r_event) begin ev_r++; ev_r_cyc = cyc; end
            if (f_event) begin ev_f++; ev_f_cyc = cyc; end
            if (b_event) ev_b++;
            if (r_clear) begin clr_n++; clr_cyc = cyc; end
            if (r_level && !pl) begin level_rises++; rise_cyc = cyc; end
            if (r_busy && !pb) busy_rises++;
            if ((r_event && pe_r) || (f_event && pe_f) || (b_event && pe_b) || (r_clear && pc))
                consec++;
            if (cnt == 12'd0 && pcnt != 12'd0) cnt_zero_cyc = cyc;
        end
        pe_r = r_event; pe_f = f_event; pe_b = b_event; pc = r_clear;
        pl = r_level; pb = r_busy; pcnt = cnt;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic val, input int n);
        raw = val;
        repeat (n) tick();
    endtask

    typedef struct packed {
        logic raw;
        logic en;
        logic lvl;
        logic ev_r;
        logic ev_f;
        logic ev_b;
        logic busy;
        logic clr;
    } vec_t;

    vec_t vecs[22];

    int s_ev_r, s_ev_f, s_ev_b, s_clr, s_busy, s_rise, e_cyc;
    bit seen;

    initial begin
        // raw en | lvl ev_r ev_f ev_b busy clr, one row per clock edge
        vecs[0]  = 8'b11_000000;
        vecs[1]  = 8'b11_000000;
        vecs[2]  = 8'b11_000010;
        vecs[3]  = 8'b11_000010;
        vecs[4]  = 8'b11_000010;
        vecs[5]  = 8'b11_110100;
        vecs[6]  = 8'b11_100000;
        vecs[7]  = 8'b11_100000;
        vecs[8]  = 8'b01_100000;
        vecs[9]  = 8'b01_100000;
        vecs[10] = 8'b01_100010;
        vecs[11] = 8'b01_100010;
        vecs[12] = 8'b01_100010;
        vecs[13] = 8'b01_001100;
        vecs[14] = 8'b01_000000;
        vecs[15] = 8'b11_000000;
        vecs[16] = 8'b11_000000;
        vecs[17] = 8'b11_000010;
        vecs[18] = 8'b01_000010;
        vecs[19] = 8'b01_000010;
        vecs[20] = 8'b01_000000;
        vecs[21] = 8'b01_000000;

        rst_n  = 1'b0;
        enable = 1'b1;
        raw    = 1'b0;
        tick();
        tick();
        check("reset level", int'({r_level, f_level, b_level}), 0);
        check("reset event", int'({r_event, f_event, b_event}), 0);
        check("reset clear", int'({r_clear, f_clear, b_clear}), 0);
        check("reset busy",  int'({r_busy, f_busy, b_busy}), 0);
        rst_n = 1'b1;

        // Latency, edge selection and glitch rejection, cycle by cycle.
        for (int i = 0; i < 22; i++) begin
            raw    = vecs[i].raw;
            enable = vecs[i].en;
            tick();
            check($sformatf("row%0d level", i), int'(r_level), int'(vecs[i].lvl));
            check($sformatf("row%0d event_rise", i), int'(r_event), int'(vecs[i].ev_r));
            check($sformatf("row%0d event_fall", i), int'(f_event), int'(vecs[i].ev_f));
            check($sformatf("row%0d event_both", i), int'(b_event), int'(vecs[i].ev_b));
            check($sformatf("row%0d busy", i), int'(r_busy), int'(vecs[i].busy));
            check($sformatf("row%0d clear", i), int'(r_clear), int'(vecs[i].clr));
        end

        // Repeated 3-cycle glitches never get through.
        s_ev_r = ev_r; s_ev_b = ev_b; s_busy = busy_rises; s_rise = level_rises;
        repeat (5) begin
            hold(1'b1, 3);
            hold(1'b0, 6);
        end
        check("glitch events", (ev_r - s_ev_r) + (ev_b - s_ev_b), 0);
        check("glitch level rises", level_rises - s_rise, 0);
        check("glitch busy pulses", busy_rises - s_busy, 5);
        check("glitch level", int'(r_level), 0);

        // 40-cycle hold: one rising event, one clear 20 edges after the rise.
        s_ev_r = ev_r; s_ev_f = ev_f; s_ev_b = ev_b; s_clr = clr_n;
        hold(1'b1, 40);
        hold(1'b0, 12);
        check("long rise events", ev_r - s_ev_r, 1);
        check("long clears", clr_n - s_clr, 1);
        check("long clear delay", clr_cyc - rise_cyc, 20);
        check("fall-mode events", ev_f - s_ev_f, 1);
        check("both-mode events", ev_b - s_ev_b, 2);
        check("rise-to-fall spacing", ev_f_cyc - ev_r_cyc, 40);

        // Re-press after release re-arms the clear.
        s_clr = clr_n;
        hold(1'b1, 25);
        hold(1'b0, 12);
        check("repress clears", clr_n - s_clr, 1);
        check("repress clear delay", clr_cyc - rise_cyc, 20);

        // Disabled press: level follows, pulses masked, timer held.
        enable = 1'b0;
        s_ev_r = ev_r; s_clr = clr_n;
        hold(1'b1, 30);
        check("disabled level", int'(r_level), 1);
        check("disabled events", ev_r - s_ev_r, 0);
        check("disabled clears", clr_n - s_clr, 0);
        enable = 1'b1;
        e_cyc  = cyc + 1;
        hold(1'b1, 25);
        check("enable-late clears", clr_n - s_clr, 1);
        check("enable-late clear time", clr_cyc, e_cyc + 19);
        hold(1'b0, 12);
        check("enable-late events", ev_r - s_ev_r, 0);

        // Reset in the middle of a qualification.
        raw  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = r_busy;
        end
        check("reached check state", int'(seen), 1);
        rst_n = 1'b0;
        raw   = 1'b0;
        #1;
        check("midreset outputs", int'({r_level, r_event, r_clear, r_busy}), 0);
        check("midreset counter", int'(cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        s_ev_r = ev_r; s_ev_b = ev_b;
        hold(1'b0, 12);
        check("post-reset events", (ev_r - s_ev_r) + (ev_b - s_ev_b), 0);
        check("post-reset level", int'(r_level), 0);

        // Downstream counter: ten clean presses, then a long press clears it.
        repeat (10) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check("count after presses", int'(cnt), 10);
        hold(1'b1, 30);
        hold(1'b0, 10);
        check("count after long press", int'(cnt), 0);
        check("count zero timing", cnt_zero_cyc, clr_cyc + 1);

        check("consecutive pulses", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
